// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: sequencer for the int8 fully-connected MAC datapath.
// On start, visits N_OUT neurons. For each neuron it streams IN_LEN feature/weight
// byte pairs from synchronous memories, then captures the saturated result.
// It tracks a running signed argmax over the neuron results and reports the winner with done.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start / busy / done        run request, run in progress, run-finished pulse
//   error                      sticky: a neuron result timed out (cleared by next start)
//   fmap_addr/fmap_rdata       feature memory port (1-cycle read latency)
//   w_addr/w_rdata             weight memory port (1-cycle read latency)
//   mac_data/mac_weight/mac_valid  datapath operand stream
//   mac_res/mac_res_valid      datapath saturated result and its valid level
//   class_idx/class_score      argmax index and score, updated at done
//   score_we/score_idx/score_val  per-neuron captured score strobe
module fc_seq_ctrl #(
    parameter int unsigned IN_LEN        = 2304,
    parameter int unsigned N_OUT         = 10,
    parameter int unsigned FADDR_W       = 12,
    parameter int unsigned WADDR_W       = 15,
    parameter int unsigned DRAIN_TIMEOUT = 16,
    localparam int unsigned IDX_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [FADDR_W-1:0] fmap_addr,
    input  logic [7:0]         fmap_rdata,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [7:0]         w_rdata,
    output logic [7:0]         mac_data,
    output logic [7:0]         mac_weight,
    output logic               mac_valid,
    input  logic [7:0]         mac_res,
    input  logic               mac_res_valid,
    output logic [IDX_W-1:0]   class_idx,
    output logic [7:0]         class_score,
    output logic               score_we,
    output logic [IDX_W-1:0]   score_idx,
    output logic [7:0]         score_val
);

    localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [WADDR_W-1:0] w_base_q, w_base_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               res_prev_q;
    logic [7:0]         best_score_q, best_score_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;

    logic               busy_d, done_d, error_d, mac_valid_d, score_we_d;
    logic [FADDR_W-1:0] fmap_addr_d;
    logic [WADDR_W-1:0] w_addr_d;
    logic [IDX_W-1:0]   class_idx_d, score_idx_d;
    logic [7:0]         class_score_d, score_val_d;
    logic               res_edge_c;

    // Only a fresh rising edge of the result level counts as a new result.
    assign res_edge_c = mac_res_valid & ~res_prev_q;

    // Read data arrives one cycle after the address, exactly when mac_valid is high.
    assign mac_data   = mac_valid ? fmap_rdata : 8'h00;
    assign mac_weight = mac_valid ? w_rdata    : 8'h00;

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        w_base_d      = w_base_q;
        tmo_d         = tmo_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        busy_d        = busy;
        done_d        = 1'b0;
        error_d       = error;
        fmap_addr_d   = fmap_addr;
        w_addr_d      = w_addr;
        mac_valid_d   = (state_q == ISSUE);
        class_idx_d   = class_idx;
        class_score_d = class_score;
        score_we_d    = 1'b0;
        score_idx_d   = score_idx;
        score_val_d   = score_val;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d      = ISSUE;
                    busy_d       = 1'b1;
                    error_d      = 1'b0;
                    n_d          = '0;
                    w_base_d     = '0;
                    fmap_addr_d  = '0;
                    w_addr_d     = '0;
                    best_score_d = 8'h80;
                    best_idx_d   = '0;
                end
            end
            ISSUE: begin
                if (fmap_addr == FADDR_W'(IN_LEN - 1)) begin
                    state_d = DRAIN;
                    tmo_d   = '0;
                end else begin
                    fmap_addr_d = fmap_addr + FADDR_W'(1);
                    w_addr_d    = w_addr + WADDR_W'(1);
                end
            end
            DRAIN: begin
                if (res_edge_c) begin
                    score_we_d  = 1'b1;
                    score_idx_d = n_q;
                    score_val_d = mac_res;
                    // Strict greater-than: ties keep the earlier (lower) index.
                    if ($signed(mac_res) > $signed(best_score_q)) begin
                        best_score_d = mac_res;
                        best_idx_d   = n_q;
                    end
                    state_d = NEXT;
                end else if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
                    error_d     = 1'b1;
                    score_we_d  = 1'b1;
                    score_idx_d = n_q;
                    score_val_d = 8'h00;
                    state_d     = NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            NEXT: begin
                if (n_q == IDX_W'(N_OUT - 1)) begin
                    state_d = DONE;
                end else begin
                    n_d         = n_q + IDX_W'(1);
                    w_base_d    = w_base_q + WADDR_W'(IN_LEN);
                    fmap_addr_d = '0;
                    w_addr_d    = w_base_q + WADDR_W'(IN_LEN);
                    state_d     = ISSUE;
                end
            end
            DONE: begin
                done_d        = 1'b1;
                class_idx_d   = best_idx_q;
                class_score_d = best_score_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            w_base_q     <= '0;
            tmo_q        <= '0;
            res_prev_q   <= 1'b0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            fmap_addr    <= '0;
            w_addr       <= '0;
            mac_valid    <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
            score_we     <= 1'b0;
            score_idx    <= '0;
            score_val    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            w_base_q     <= w_base_d;
            tmo_q        <= tmo_d;
            res_prev_q   <= mac_res_valid;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            fmap_addr    <= fmap_addr_d;
            w_addr       <= w_addr_d;
            mac_valid    <= mac_valid_d;
            class_idx    <= class_idx_d;
            class_score  <= class_score_d;
            score_we     <= score_we_d;
            score_idx    <= score_idx_d;
            score_val    <= score_val_d;
        end
    end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Testbench for fc_seq_ctrl: a small instance (IN_LEN=4, N_OUT=3) for directed
// result/argmax/timeout/reset vectors, and a default-size instance for the full address sweep.
module tb_fc_seq_ctrl;

    localparam int unsigned S_IN  = 4;
    localparam int unsigned S_OUT = 3;
    localparam int unsigned S_FW  = 2;
    localparam int unsigned S_WW  = 4;
    localparam int unsigned S_IW  = 2;
    localparam int unsigned B_IN  = 2304;
    localparam int unsigned B_OUT = 10;
    localparam int unsigned B_FW  = 12;
    localparam int unsigned B_WW  = 15;
    localparam int unsigned B_IW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- small instance ----------------
    logic            s_reset, s_start, s_busy, s_done, s_error;
    logic [S_FW-1:0] s_fmap_addr;
    logic [S_WW-1:0] s_w_addr;
    logic [7:0]      s_fmap_rdata, s_w_rdata, s_mac_data, s_mac_weight;
    logic            s_mac_valid;
    logic [7:0]      s_mac_res = 8'h00;
    logic            s_mac_res_valid = 1'b0;
    logic [S_IW-1:0] s_class_idx, s_score_idx;
    logic [7:0]      s_class_score, s_score_val;
    logic            s_score_we;

    fc_seq_ctrl #(.IN_LEN(S_IN), .N_OUT(S_OUT), .FADDR_W(S_FW), .WADDR_W(S_WW),
                  .DRAIN_TIMEOUT(16)) u_small (
        .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
        .error(s_error), .fmap_addr(s_fmap_addr), .fmap_rdata(s_fmap_rdata),
        .w_addr(s_w_addr), .w_rdata(s_w_rdata), .mac_data(s_mac_data),
        .mac_weight(s_mac_weight), .mac_valid(s_mac_valid), .mac_res(s_mac_res),
        .mac_res_valid(s_mac_res_valid), .class_idx(s_class_idx),
        .class_score(s_class_score), .score_we(s_score_we), .score_idx(s_score_idx),
        .score_val(s_score_val)
    );

    logic [7:0] s_fmem [S_IN];
    logic [7:0] s_wmem [S_IN*S_OUT];
    always @(posedge clk) begin
        s_fmap_rdata <= s_fmem[s_fmap_addr];
        s_w_rdata    <= s_wmem[s_w_addr];
    end

    function automatic logic [7:0] sat8(input int v);
        if (v > 127)  return 8'h7f;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    // Datapath model: accumulate while mac_valid, result pulse 3 cycles after the stream ends.
    int         s_acc = 0, s_dly = 0, s_nbr = 0, s_withhold = -1;
    logic [7:0] s_pend = 8'h00;
    logic       s_mvq = 1'b0;
    always @(posedge clk) begin
        s_mac_res_valid <= 1'b0;
        if (s_reset) begin
            s_acc = 0; s_dly = 0; s_nbr = 0; s_mvq = 1'b0;
        end else begin
            if (s_mac_valid)
                s_acc += int'($signed(s_mac_data)) * int'($signed(s_mac_weight));
            if (s_mvq && !s_mac_valid) begin
                s_pend = sat8(s_acc);
                s_acc  = 0;
                s_dly  = (s_nbr == s_withhold) ? 0 : 3;
                s_nbr  = (s_nbr == int'(S_OUT) - 1) ? 0 : s_nbr + 1;
            end else if (s_dly != 0) begin
                s_dly--;
                if (s_dly == 0) begin
                    s_mac_res_valid <= 1'b1;
                    s_mac_res       <= s_pend;
                end
            end
            s_mvq = s_mac_valid;
        end
    end

    // Monitor: score strobes, done pulses, mac_valid run lengths and gaps.
    int              s_sw_cnt = 0, s_done_cnt = 0, s_runs = 0, s_run_bad = 0;
    int              s_run_len = 0, s_gap = 99;
    logic [S_IW-1:0] s_sw_idx [64];
    logic [7:0]      s_sw_val [64];
    logic [S_IW-1:0] s_done_idx;
    logic [7:0]      s_done_score;
    always @(negedge clk) begin
        if (s_score_we) begin
            s_sw_idx[s_sw_cnt % 64] = s_score_idx;
            s_sw_val[s_sw_cnt % 64] = s_score_val;
            s_sw_cnt++;
        end
        if (s_done) begin
            s_done_cnt++;
            s_done_idx   = s_class_idx;
            s_done_score = s_class_score;
        end
        if (s_mac_valid) begin
            if (s_run_len == 0 && s_gap < 2) s_run_bad++;
            s_run_len++;
            s_gap = 0;
        end else begin
            if (s_run_len != 0) begin
                s_runs++;
                if (s_run_len != int'(S_IN)) s_run_bad++;
            end
            s_run_len = 0;
            s_gap++;
        end
    end

    // ---------------- default-size instance ----------------
    logic            b_reset, b_start, b_busy, b_done, b_error;
    logic [B_FW-1:0] b_fmap_addr;
    logic [B_WW-1:0] b_w_addr;
    logic [7:0]      b_fmap_rdata, b_w_rdata, b_mac_data, b_mac_weight;
    logic            b_mac_valid;
    logic [7:0]      b_mac_res = 8'h00;
    logic            b_mac_res_valid = 1'b0;
    logic [B_IW-1:0] b_class_idx, b_score_idx;
    logic [7:0]      b_class_score, b_score_val;
    logic            b_score_we;

    fc_seq_ctrl u_big (
        .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
        .error(b_error), .fmap_addr(b_fmap_addr), .fmap_rdata(b_fmap_rdata),
        .w_addr(b_w_addr), .w_rdata(b_w_rdata), .mac_data(b_mac_data),
        .mac_weight(b_mac_weight), .mac_valid(b_mac_valid), .mac_res(b_mac_res),
        .mac_res_valid(b_mac_res_valid), .class_idx(b_class_idx),
        .class_score(b_class_score), .score_we(b_score_we), .score_idx(b_score_idx),
        .score_val(b_score_val)
    );

    logic [7:0] b_fmem [B_IN];
    logic [7:0] b_wmem [B_IN*B_OUT];
    always @(posedge clk) begin
        b_fmap_rdata <= b_fmem[b_fmap_addr];
        b_w_rdata    <= b_wmem[b_w_addr];
    end

    // Result for neuron i is 3*i, so the winner is neuron 9 with score 27.
    int   b_dly = 0, b_nbr = 0;
    logic b_mvq = 1'b0;
    always @(posedge clk) begin
        b_mac_res_valid <= 1'b0;
        if (b_reset) begin
            b_dly = 0; b_nbr = 0; b_mvq = 1'b0;
        end else begin
            if (b_mvq && !b_mac_valid) begin
                b_dly = 3;
            end else if (b_dly != 0) begin
                b_dly--;
                if (b_dly == 0) begin
                    b_mac_res_valid <= 1'b1;
                    b_mac_res       <= 8'(b_nbr * 3);
                    b_nbr++;
                end
            end
            b_mvq = b_mac_valid;
        end
    end

    // Address/data sweep monitor: previous-cycle address must equal the expected index.
    int b_ef = 0, b_ew = 0, b_bad = 0, b_vcnt = 0, b_maxf = 0, b_maxw = 0, b_pf = 0, b_pw = 0;
    int b_sw_cnt = 0;
    always @(negedge clk) begin
        if (b_mac_valid) begin
            if (b_mac_data !== b_fmem[b_ef] || b_mac_weight !== b_wmem[b_ew] ||
                b_pf != b_ef || b_pw != b_ew)
                b_bad++;
            b_vcnt++;
            b_ew++;
            b_ef = (b_ef == int'(B_IN) - 1) ? 0 : b_ef + 1;
        end
        if (b_score_we) b_sw_cnt++;
        if (int'(b_fmap_addr) > b_maxf) b_maxf = int'(b_fmap_addr);
        if (int'(b_w_addr) > b_maxw) b_maxw = int'(b_w_addr);
        b_pf = int'(b_fmap_addr);
        b_pw = int'(b_w_addr);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic s_pulse_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    // Bytes of each word are one neuron's four weights.
    task automatic s_set_w(input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2);
        for (int k = 0; k < 4; k++) begin
            s_wmem[k]     = n0[8*k +: 8];
            s_wmem[4 + k] = n1[8*k +: 8];
            s_wmem[8 + k] = n2[8*k +: 8];
        end
    endtask

    task automatic s_wait_done(input int d0);
        for (int i = 0; i < 600; i++) begin
            if (s_done_cnt != d0) return;
            tick();
        end
        check_val("s_done_timeout", 32'(s_done_cnt - d0), 32'd1);
    endtask

    // Run one classification and compare scores, argmax, error and done/busy timing.
    task automatic s_run(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] v2, input logic [1:0] ci, input logic [7:0] cs,
                         input logic err);
        int sw0, d0;
        logic [7:0] ev [3];
        ev[0] = v0; ev[1] = v1; ev[2] = v2;
        sw0 = s_sw_cnt;
        d0  = s_done_cnt;
        s_pulse_start();
        s_wait_done(d0);
        check_val({tag, "_nscores"}, 32'(s_sw_cnt - sw0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val({tag, "_score_idx"}, 32'(s_sw_idx[(sw0 + i) % 64]), 32'(i));
            check_val({tag, "_score_val"}, 32'(s_sw_val[(sw0 + i) % 64]), 32'(ev[i]));
        end
        check_val({tag, "_class_idx"}, 32'(s_done_idx), 32'(ci));
        check_val({tag, "_class_score"}, 32'(s_done_score), 32'(cs));
        check_val({tag, "_error"}, 32'(s_error), 32'(err));
        check_val({tag, "_busy_at_done"}, 32'(s_busy), 32'd1);
        tick();
        check_val({tag, "_done_pulse"}, 32'(s_done), 32'd0);
        check_val({tag, "_busy_after"}, 32'(s_busy), 32'd0);
        check_val({tag, "_class_hold"}, 32'(s_class_idx), 32'(ci));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r0, rb0, sw0, d0, bd0;
        s_reset = 1'b1; b_reset = 1'b1;
        s_start = 1'b0; b_start = 1'b0;
        for (int i = 0; i < int'(S_IN); i++) s_fmem[i] = 8'd1;
        for (int i = 0; i < int'(B_IN); i++) b_fmem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < int'(B_IN * B_OUT); i++) b_wmem[i] = 8'(i * 13 + 5);
        s_set_w(32'h0, 32'h0, 32'h0);
        repeat (3) tick();
        s_reset = 1'b0; b_reset = 1'b0;
        tick();

        check_val("rst_busy", 32'(s_busy), 32'd0);
        check_val("rst_done", 32'(s_done), 32'd0);
        check_val("rst_error", 32'(s_error), 32'd0);
        check_val("rst_fmap_addr", 32'(s_fmap_addr), 32'd0);
        check_val("rst_w_addr", 32'(s_w_addr), 32'd0);
        check_val("rst_mac_valid", 32'(s_mac_valid), 32'd0);
        check_val("rst_class_idx", 32'(s_class_idx), 32'd0);
        check_val("rst_score_we", 32'(s_score_we), 32'd0);

        // 5, -7, 20 -> class 2; weights {2,1,1,1}, {-1,-2,-3,-1}, {5,5,5,5}.
        s_set_w(32'h01010102, 32'hFFFDFEFF, 32'h05050505);
        r0 = s_runs; rb0 = s_run_bad;
        s_run("basic", 8'd5, 8'hF9, 8'd20, 2'd2, 8'd20, 1'b0);
        check_val("basic_mac_runs", 32'(s_runs - r0), 32'd3);
        check_val("basic_run_shape", 32'(s_run_bad - rb0), 32'd0);

        // 9, 9, 3 -> tie keeps index 0.
        s_set_w(32'h00000009, 32'h00030303, 32'h00010101);
        s_run("tie", 8'd9, 8'd9, 8'd3, 2'd0, 8'd9, 1'b0);

        // All saturate to -128 -> index 0, score -128.
        s_set_w(32'h80808080, 32'h80808080, 32'h80808080);
        s_run("allneg", 8'h80, 8'h80, 8'h80, 2'd0, 8'h80, 1'b0);

        // Neuron 1 result withheld -> timeout score 0, error set, run still completes.
        s_set_w(32'h01010102, 32'hFFFDFEFF, 32'h05050505);
        s_withhold = 1;
        s_run("timeout", 8'd5, 8'd0, 8'd20, 2'd2, 8'd20, 1'b1);
        check_val("timeout_error_sticky", 32'(s_error), 32'd1);
        s_withhold = -1;

        // Next accepted start clears error.
        d0 = s_done_cnt;
        s_pulse_start();
        check_val("errclr_error", 32'(s_error), 32'd0);
        check_val("errclr_busy", 32'(s_busy), 32'd1);
        s_wait_done(d0);
        check_val("errclr_class_idx", 32'(s_done_idx), 32'd2);
        check_val("errclr_error_end", 32'(s_error), 32'd0);
        tick();

        // Reset in the middle of neuron 2's stream.
        sw0 = s_sw_cnt;
        s_pulse_start();
        for (int i = 0; i < 200 && s_sw_cnt < sw0 + 2; i++) tick();
        for (int i = 0; i < 50 && !s_mac_valid; i++) tick();
        check_val("midrst_in_stream", 32'(s_mac_valid), 32'd1);
        check_val("midrst_neuron1_idx", 32'(s_score_idx), 32'd1);
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        check_val("midrst_busy", 32'(s_busy), 32'd0);
        check_val("midrst_done", 32'(s_done), 32'd0);
        check_val("midrst_fmap_addr", 32'(s_fmap_addr), 32'd0);
        check_val("midrst_w_addr", 32'(s_w_addr), 32'd0);
        check_val("midrst_mac_valid", 32'(s_mac_valid), 32'd0);
        check_val("midrst_mac_data", 32'(s_mac_data), 32'd0);
        check_val("midrst_mac_weight", 32'(s_mac_weight), 32'd0);
        check_val("midrst_class_idx", 32'(s_class_idx), 32'd0);
        check_val("midrst_class_score", 32'(s_class_score), 32'd0);
        check_val("midrst_score_idx", 32'(s_score_idx), 32'd0);
        check_val("midrst_score_val", 32'(s_score_val), 32'd0);
        sw0 = s_sw_cnt;
        repeat (30) tick();
        check_val("midrst_idle_scores", 32'(s_sw_cnt - sw0), 32'd0);
        check_val("midrst_idle_busy", 32'(s_busy), 32'd0);

        // Clean run from n=0 with a spurious start while busy.
        sw0 = s_sw_cnt;
        d0  = s_done_cnt;
        s_pulse_start();
        repeat (2) tick();
        s_pulse_start();
        s_wait_done(d0);
        check_val("rerun_class_idx", 32'(s_done_idx), 32'd2);
        check_val("rerun_class_score", 32'(s_done_score), 32'd20);
        check_val("rerun_first_idx", 32'(s_sw_idx[sw0 % 64]), 32'd0);
        check_val("rerun_first_val", 32'(s_sw_val[sw0 % 64]), 32'd5);
        repeat (60) tick();
        check_val("rerun_nscores", 32'(s_sw_cnt - sw0), 32'd3);
        check_val("rerun_ndone", 32'(s_done_cnt - d0), 32'd1);

        // Full-size address sweep.
        bd0 = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 30000 && !b_done; i++) tick();
        check_val("big_done", 32'(b_done), 32'd1);
        bd0 = b_bad;
        check_val("big_stream_mismatches", 32'(bd0), 32'd0);
        check_val("big_mac_valid_cycles", 32'(b_vcnt), 32'(B_IN * B_OUT));
        check_val("big_max_fmap_addr", 32'(b_maxf), 32'(B_IN - 1));
        check_val("big_max_w_addr", 32'(b_maxw), 32'(B_IN * B_OUT - 1));
        check_val("big_nscores", 32'(b_sw_cnt), 32'd10);
        check_val("big_class_idx", 32'(b_class_idx), 32'd9);
        check_val("big_class_score", 32'(b_class_score), 32'd27);
        check_val("big_error", 32'(b_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
